// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit stepping fetch T0-T2 and an opcode-driven execute sequence up to T7.
// Define ILLEGAL_TRAP_EN to trap undefined opcodes into HALT and report them on illegal/illegal_opc.
module control_sequencer #(
    parameter int OPC_W      = 5,
    parameter int OPC_LSB    = 27,
    parameter int ALUOP_W    = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic [31:0]        IR,
    input  logic               MemReady,
    input  logic               CON,
    input  logic               Stop,
    output logic               PCout,
    output logic               Zhiout,
    output logic               Zlowout,
    output logic               MDRout,
    output logic               MARin,
    output logic               Zin,
    output logic               PCin,
    output logic               MDRin,
    output logic               IRin,
    output logic               Yin,
    output logic               IncPC,
    output logic               Read,
    output logic               Write,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               Rin,
    output logic               Rout,
    output logic               BAout,
    output logic               Cout,
    output logic               CONin,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         step,
    output logic               Run,
    output logic               Fault
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               illegal,
    output logic [OPC_W-1:0]   illegal_opc
`endif
);

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(18);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd14,
        S_RST  = 4'd15
    } state_t;

    state_t           state;
    state_t           last_step;
    logic [7:0]       wait_cnt;
    logic [OPC_W-1:0] opc;
    logic             is_ld, is_ldi, is_st, is_alu, is_alui, is_br, is_halt_op;
    logic             mem_wait, is_last, halt_now;
    logic             unused_ir;

    function automatic logic [ALUOP_W-1:0] alu_code(input logic [OPC_W-1:0] op);
        if (op == OP_SUB) return ALUOP_W'(1);
        if (op == OP_AND || op == OP_ANDI) return ALUOP_W'(2);
        if (op == OP_OR || op == OP_ORI) return ALUOP_W'(3);
        return '0;
    endfunction

    assign opc        = IR[OPC_LSB+OPC_W-1:OPC_LSB];
    assign unused_ir  = ^IR;
    assign is_ld      = (opc == OP_LD);
    assign is_ldi     = (opc == OP_LDI);
    assign is_st      = (opc == OP_ST);
    assign is_alu     = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    assign is_alui    = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
    assign is_br      = (opc == OP_BR);
    assign is_halt_op = (opc == OP_HALT);

    // Instruction length by class; unknown opcodes finish at T3 like nop.
    assign last_step = (is_ld || is_st) ? S_T7 :
                       (is_ldi || is_alu || is_alui) ? S_T5 :
                       is_br ? S_T6 : S_T3;
    assign is_last   = (state == last_step);
    assign mem_wait  = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);

`ifdef ILLEGAL_TRAP_EN
    logic is_defined;
    assign is_defined = is_ld || is_ldi || is_st || is_alu || is_alui || is_br || is_halt_op ||
                        (opc == OPC_W'(26));
    assign halt_now   = (state == S_T3) && (is_halt_op || !is_defined);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            illegal     <= 1'b0;
            illegal_opc <= '0;
        end else if (state == S_T3 && !is_defined) begin
            illegal     <= 1'b1;
            illegal_opc <= opc;
        end
    end
`else
    assign halt_now = (state == S_T3) && is_halt_op;
`endif

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state    <= S_RST;
            wait_cnt <= '0;
            Fault    <= 1'b0;
        end else begin
            case (state)
                S_RST: begin
                    state    <= S_T0;
                    wait_cnt <= '0;
                end
                S_HALT: ;
                default: begin
                    if (mem_wait && !MemReady) begin
                        if (wait_cnt == 8'(WAIT_LIMIT - 1)) begin
                            Fault <= 1'b1;
                            state <= S_HALT;
                        end
                        wait_cnt <= wait_cnt + 8'd1;
                    end else begin
                        wait_cnt <= '0;
                        if (halt_now)     state <= S_HALT;
                        else if (is_last) state <= Stop ? S_HALT : S_T0;
                        else              state <= state_t'(state + 4'd1);
                    end
                end
            endcase
        end
    end

    assign step = state;
    assign Run  = (state != S_HALT) && (state != S_RST);

    // IR and the CON flip-flop are datapath registers, so strobes decode live from them alongside the state.
    always_comb begin
        PCout = 1'b0; Zhiout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin = 1'b0;
        Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; IncPC = 1'b0;
        Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0;
        Rout = 1'b0; BAout = 1'b0; Cout = 1'b0; CONin = 1'b0;
        alu_op = '0;
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_ld || is_ldi || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_alu || is_alui) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end
            end
            S_T4: begin
                if (is_ld || is_ldi || is_st) begin
                    Cout = 1'b1; Zin = 1'b1;
                end else if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_code(opc);
                end else if (is_alui) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = alu_code(opc);
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_ldi || is_alu || is_alui) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br && CON) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
